// File: rtl/fpmul_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin floating-point multiplier arbiter.
package fpmul_arb_pkg;

    localparam int          FP_W   = 32;
    localparam logic [31:0] FP_NAN = 32'h7F80_0001;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } arb_state_e;

endpackage

// File: rtl/fpmul_rr_arbiter_if.sv
// Requester and multiplier bus of the arbiter.
// slave = arbiter side, master = requesters plus the multiplier.
interface fpmul_rr_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import fpmul_arb_pkg::*;

    logic [NUM_REQ-1:0]      req_valid;
    logic [FP_W*NUM_REQ-1:0] req_a;
    logic [FP_W*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]      req_grant;
    logic [NUM_REQ-1:0]      resp_valid;
    logic [FP_W-1:0]         resp_y;
    logic                    mul_start;
    logic [FP_W-1:0]         mul_a;
    logic [FP_W-1:0]         mul_b;
    logic                    mul_ready;
    logic                    mul_busy;
    logic [FP_W-1:0]         mul_y;

    modport slave (
        input  req_valid, req_a, req_b, mul_ready, mul_busy, mul_y,
        output req_grant, resp_valid, resp_y, mul_start, mul_a, mul_b
    );

    modport master (
        output req_valid, req_a, req_b, mul_ready, mul_busy, mul_y,
        input  req_grant, resp_valid, resp_y, mul_start, mul_a, mul_b
    );

endinterface

// File: rtl/fpmul_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: the first asserted request searching
// upward from rr_ptr+1, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_any
);

    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    assign o_any = |i_req;

    // Rotating priority search starting just after the last winner.
    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(i_rr_ptr) + k) % NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                w_found  = 1'b1;
                o_winner = w_idx;
            end else begin
                w_found  = w_found;
            end
        end
    end

endmodule

// File: rtl/fpmul_rr_arbiter.sv
// Round-robin arbiter sharing one single-issue FP multiplier among NUM_REQ
// requesters. Operands are latched at grant; one multiplication in flight.
// Optional watchdog in WAIT enabled by defining FPMUL_ARB_TIMEOUT_EN.
module fpmul_rr_arbiter
    import fpmul_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int IDX_W          = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    fpmul_rr_arbiter_if.slave  bus,
    output logic [IDX_W-1:0]   cur_idx
`ifdef FPMUL_ARB_TIMEOUT_EN
    ,
    output logic               timeout_err
`endif
);

    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);

    arb_state_e       r_state, w_state_nxt;
    logic [IDX_W-1:0] r_rr_ptr, r_cur_idx, w_win;
    logic             w_any, w_go, w_ready_ok, w_tout;
    logic             r_first;
    logic [NUM_REQ-1:0] r_grant, r_resp_valid, w_grant_nxt, w_resp_valid_nxt;
    logic             r_mul_start, w_start_nxt;
    logic             r_timeout_err, w_terr_nxt;
    logic [FP_W-1:0]  r_mul_a, r_mul_b, r_resp_y;
    logic [FP_W-1:0]  w_a_arr [NUM_REQ];
    logic [FP_W-1:0]  w_b_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign w_a_arr[g] = bus.req_a[g*FP_W +: FP_W];
        assign w_b_arr[g] = bus.req_b[g*FP_W +: FP_W];
    end

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .i_req    (bus.req_valid),
        .i_rr_ptr (r_rr_ptr),
        .o_winner (w_win),
        .o_any    (w_any)
    );

    // A stale ready from a multiplier that was not reset always comes with
    // busy=1, so requiring both low keeps it from being taken as a new result.
    assign w_go       = w_any & ~bus.mul_busy & ~bus.mul_ready;
    assign w_ready_ok = ~r_first & bus.mul_ready;

`ifdef FPMUL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_tout_flag;

    assign w_tout = (r_state == WAIT) & ~w_ready_ok &
                    (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts WAIT cycles and remembers a timeout until DELIVER.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd_cnt    <= '0;
            r_tout_flag <= 1'b0;
        end else if (r_state == WAIT) begin
            r_wd_cnt    <= r_wd_cnt + CNT_W'(1);
            r_tout_flag <= w_tout;
        end else begin
            r_wd_cnt    <= '0;
            r_tout_flag <= r_tout_flag;
        end
    end
`else
    assign w_tout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_go) w_state_nxt = ISSUE; else w_state_nxt = IDLE;
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    if (w_ready_ok || w_tout) w_state_nxt = DELIVER; else w_state_nxt = WAIT;
            DELIVER: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode: next values of the registered one-cycle pulses.
    always_comb begin
        w_grant_nxt      = '0;
        w_resp_valid_nxt = '0;
        w_start_nxt      = 1'b0;
        w_terr_nxt       = 1'b0;
        case (r_state)
            IDLE:    if (w_go) w_grant_nxt[w_win] = 1'b1; else w_grant_nxt = '0;
            ISSUE:   w_start_nxt = 1'b1;
            WAIT:    w_start_nxt = 1'b0;
            DELIVER: begin
                w_resp_valid_nxt[r_cur_idx] = 1'b1;
`ifdef FPMUL_ARB_TIMEOUT_EN
                w_terr_nxt = r_tout_flag;
`endif
            end
            default: w_start_nxt = 1'b0;
        endcase
    end

    // Registered handshake pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant       <= '0;
            r_resp_valid  <= '0;
            r_mul_start   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_grant       <= w_grant_nxt;
            r_resp_valid  <= w_resp_valid_nxt;
            r_mul_start   <= w_start_nxt;
            r_timeout_err <= w_terr_nxt;
        end
    end

    // Datapath: operand latch at grant, pointer update, result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            r_cur_idx <= '0;
            r_rr_ptr  <= PTR_RST;
            r_resp_y  <= '0;
            r_first   <= 1'b0;
        end else begin
            r_first <= (r_state == ISSUE);
            if (r_state == IDLE && w_go) begin
                r_mul_a   <= w_a_arr[w_win];
                r_mul_b   <= w_b_arr[w_win];
                r_cur_idx <= w_win;
                r_rr_ptr  <= w_win;
            end
            if (r_state == WAIT && w_ready_ok) begin
                r_resp_y <= bus.mul_y;
            end else if (w_tout) begin
                r_resp_y <= FP_NAN;
            end
        end
    end

    assign bus.req_grant  = r_grant;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_y     = r_resp_y;
    assign bus.mul_start  = r_mul_start;
    assign bus.mul_a      = r_mul_a;
    assign bus.mul_b      = r_mul_b;
    assign cur_idx        = r_cur_idx;
`ifdef FPMUL_ARB_TIMEOUT_EN
    assign timeout_err    = r_timeout_err;
`else
    logic w_unused_terr;
    assign w_unused_terr  = r_timeout_err;
`endif

endmodule

// File: tb/tb_fpmul_rr_arbiter.sv
// Directed bench for fpmul_rr_arbiter with a stub multiplier whose products
// come from a hand-computed table. Watchdog case under FPMUL_ARB_TIMEOUT_EN.
module tb_fpmul_rr_arbiter;
    import fpmul_arb_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fpmul_rr_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();
    logic [IDX_W-1:0] cur_idx;
`ifdef FPMUL_ARB_TIMEOUT_EN
    logic timeout_err;
`endif

    fpmul_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .TIMEOUT_CYCLES(64)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .cur_idx (cur_idx)
`ifdef FPMUL_ARB_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    // ---------------- stub multiplier ----------------
    function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return 32'h40000000; // 1*2
            {32'h40000000, 32'h40000000}: return 32'h40800000; // 2*2
            {32'h40400000, 32'h40000000}: return 32'h40C00000; // 3*2
            {32'h40800000, 32'h40000000}: return 32'h41000000; // 4*2
            {32'h40000000, 32'h40400000}: return 32'h40C00000; // 2*3
            {32'h7F800000, 32'h3F800000}: return 32'h7F800000; // inf*1
            {32'h7FC00000, 32'h40000000}: return 32'h7FC00000; // qNaN*2
            {32'hBF800000, 32'h40400000}: return 32'hC0400000; // -1*3
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    logic        stub_busy = 1'b0, stub_ready = 1'b0, stub_hang = 1'b0, frc_busy = 1'b0;
    logic [31:0] stub_y = 32'h0;
    int          stub_lat = 3, stub_cnt = 0;

    assign bus.mul_busy  = stub_busy | frc_busy;
    assign bus.mul_ready = stub_ready;
    assign bus.mul_y     = stub_y;

    always @(posedge clk) begin
        stub_ready <= 1'b0;
        if (stub_busy) begin
            if (stub_cnt == 1) stub_ready <= 1'b1;
            if (stub_cnt == 0) stub_busy <= 1'b0;
            stub_cnt <= stub_cnt - 1;
        end else if (bus.mul_start && !stub_hang) begin
            stub_busy <= 1'b1;
            stub_cnt  <= stub_lat - 1;
            stub_y    <= mul_model(bus.mul_a, bus.mul_b);
        end
    end

    // ---------------- event monitor ----------------
    typedef struct { int idx; logic [3:0] vec; int cyc; int open; } gev_t;
    typedef struct { int idx; logic [3:0] vec; logic [31:0] y; int cyc; logic terr; } rev_t;
    gev_t gq[$];
    rev_t rq[$];
    int   cyc = 0, n_start = 0, n_open = 0;

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic t;
`ifdef FPMUL_ARB_TIMEOUT_EN
        t = timeout_err;
`else
        t = 1'b0;
`endif
        if (reset) n_open = 0;
        if (|bus.req_grant) begin
            gq.push_back('{oh_idx(bus.req_grant), bus.req_grant, cyc, n_open});
            n_open = n_open + 1;
        end
        if (|bus.resp_valid) begin
            rq.push_back('{oh_idx(bus.resp_valid), bus.resp_valid, bus.resp_y, cyc, t});
            n_open = n_open - 1;
        end
        if (bus.mul_start) n_start = n_start + 1;
    end

    // ---------------- checking helpers ----------------
    int n_asserts = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
        bus.req_valid[i]      = 1'b1;
    endtask

    // Runs until rq holds target entries; drops a requester's valid on its grant
    // (or all valids once drop_after grants were seen when keep is set).
    task automatic serve(input int rtarget, input int budget, input bit keep,
                         input int gtarget, output bit ok);
        int seen;
        seen = gq.size();
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            tick();
            while (seen < gq.size()) begin
                if (!keep) bus.req_valid[gq[seen].idx] = 1'b0;
                seen++;
            end
            if (keep && gq.size() >= gtarget) bus.req_valid = '0;
            if (rq.size() >= rtarget) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct { int idx; logic [31:0] a; logic [31:0] b; logic [31:0] y; int lat; } vec_t;
    vec_t vt[4];

    initial begin
        bit ok;
        int gb, rb, sb, gc, bcyc;
        logic [31:0] exp2 [4];
        logic [31:0] op2 [4];

        vt[0] = '{0, 32'h40000000, 32'h40400000, 32'h40C00000, 3};
        vt[1] = '{2, 32'h7F800000, 32'h3F800000, 32'h7F800000, 4};
        vt[2] = '{1, 32'h7FC00000, 32'h40000000, 32'h7FC00000, 3};
        vt[3] = '{3, 32'hBF800000, 32'h40400000, 32'hC0400000, 6};
        op2  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        exp2 = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset values
        chk("rst_grant", bus.req_grant, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_y", bus.resp_y, 0);
        chk("rst_mul_start", bus.mul_start, 0);
        chk("rst_mul_a", bus.mul_a, 0);
        chk("rst_mul_b", bus.mul_b, 0);
        chk("rst_cur_idx", cur_idx, 0);

        // All four continuously valid: order 0,1,2,3,0, one in flight
        gb = gq.size(); rb = rq.size();
        stub_lat = 3;
        for (int i = 0; i < 4; i++) set_req(i, op2[i], 32'h40000000);
        serve(rb + 5, 300, 1'b1, gb + 5, ok);
        chk("fair_done", ok, 1);
        if (ok) begin
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("fair_grant%0d", k), gq[gb+k].idx, k % 4);
                chk($sformatf("fair_open%0d", k), gq[gb+k].open, 0);
                chk($sformatf("fair_resp_idx%0d", k), rq[rb+k].idx, k % 4);
                chk($sformatf("fair_resp_y%0d", k), rq[rb+k].y, exp2[k % 4]);
                chk($sformatf("fair_lat%0d", k), rq[rb+k].cyc - gq[gb+k].cyc, 6);
            end
        end

        // Single-requester vectors
        for (int v = 0; v < 4; v++) begin
            gb = gq.size(); rb = rq.size(); sb = n_start;
            stub_lat = vt[v].lat;
            set_req(vt[v].idx, vt[v].a, vt[v].b);
            serve(rb + 1, 200, 1'b0, 0, ok);
            chk($sformatf("v%0d_done", v), ok, 1);
            if (ok) begin
                chk($sformatf("v%0d_grant_vec", v), gq[gb].vec, 4'b0001 << vt[v].idx);
                chk($sformatf("v%0d_resp_vec", v), rq[rb].vec, 4'b0001 << vt[v].idx);
                chk($sformatf("v%0d_resp_y", v), rq[rb].y, vt[v].y);
                chk($sformatf("v%0d_latency", v), rq[rb].cyc - gq[gb].cyc, vt[v].lat + 3);
                chk($sformatf("v%0d_starts", v), n_start - sb, 1);
`ifdef FPMUL_ARB_TIMEOUT_EN
                chk($sformatf("v%0d_terr", v), rq[rb].terr, 0);
`endif
            end
            repeat (2) tick();
        end

        // Reset while waiting; stale ready arrives with busy=1 afterwards
        gb = gq.size(); rb = rq.size();
        stub_lat = 3;
        set_req(0, 32'h40000000, 32'h40400000);
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            tick();
            if (gq.size() > gb) ok = 1'b1;
        end
        chk("rstw_grant_seen", ok, 1);
        if (ok) begin
            bus.req_valid = '0;
            gc = gq[gb].cyc;
            while (cyc < gc + 2) tick();
            reset = 1'b1;
            tick();
            reset = 1'b0;
            set_req(0, 32'h40000000, 32'h40400000);
            set_req(1, 32'h40000000, 32'h40000000);
            serve(rb + 2, 200, 1'b0, 0, ok);
            chk("rstw_done", ok, 1);
            if (ok) begin
                chk("rstw_regrant_idx", gq[gb+1].idx, 0);
                chk("rstw_regrant_cyc", gq[gb+1].cyc - gc, 6);
                chk("rstw_no_stale_resp", rq[rb].cyc > gq[gb+1].cyc, 1);
                chk("rstw_resp0_idx", rq[rb].idx, 0);
                chk("rstw_resp0_y", rq[rb].y, 32'h40C00000);
                chk("rstw_resp1_idx", rq[rb+1].idx, 1);
                chk("rstw_resp1_y", rq[rb+1].y, 32'h40800000);
            end
        end
        repeat (2) tick();

        // Busy held in IDLE blocks the grant until it drops
        gb = gq.size(); rb = rq.size();
        frc_busy = 1'b1;
        set_req(1, 32'h40400000, 32'h40000000);
        repeat (6) tick();
        chk("busy_no_grant", gq.size() - gb, 0);
        frc_busy = 1'b0;
        bcyc = cyc;
        serve(rb + 1, 100, 1'b0, 0, ok);
        chk("busy_done", ok, 1);
        if (ok) begin
            chk("busy_grant_cyc", gq[gb].cyc - bcyc, 1);
            chk("busy_grant_idx", gq[gb].idx, 1);
            chk("busy_resp_y", rq[rb].y, 32'h40C00000);
        end
        repeat (2) tick();

`ifdef FPMUL_ARB_TIMEOUT_EN
        // Watchdog: multiplier never answers
        gb = gq.size(); rb = rq.size();
        stub_hang = 1'b1;
        set_req(3, 32'h40000000, 32'h40000000);
        serve(rb + 1, 200, 1'b0, 0, ok);
        chk("tout_done", ok, 1);
        if (ok) begin
            chk("tout_resp_idx", rq[rb].idx, 3);
            chk("tout_resp_y", rq[rb].y, 32'h7F800001);
            chk("tout_terr", rq[rb].terr, 1);
            chk("tout_latency", rq[rb].cyc - gq[gb].cyc, 66);
        end
        stub_hang = 1'b0;
        repeat (2) tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1);
    end

endmodule

// File: doc/fpmul_rr_arbiter.md
Name: fpmul_rr_arbiter

Overview:
Shares one single-issue floating-point multiplier (start/ready/busy handshake, 32-bit IEEE-754 single operands) among NUM_REQ requesters in the sum-of-squared-error datapath. Round-robin arbitration; operands are latched at grant. The arbiter sequences the start pulse, waits for ready, and returns the product to the granted requester with a one-cycle valid pulse. Only one multiplication is in flight at a time.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDX_W, $clog2(NUM_REQ), width of the requester index
TIMEOUT_CYCLES, 64, watchdog limit in WAIT; used only with the optional feature

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request; held until the matching req_grant bit
req_a  in  32*NUM_REQ  operand A, slice i for requester i; stable while req_valid[i]=1
req_b  in  32*NUM_REQ  operand B, slice i
req_grant  out  NUM_REQ  one-hot, one-cycle pulse; operands sampled in this cycle
resp_valid  out  NUM_REQ  one-hot, one-cycle pulse carrying the result
resp_y  out  32  product; valid only with resp_valid
mul_start  out  1  start to the multiplier
mul_a, mul_b  out  32 each  operands to the multiplier
mul_ready  in  1  multiplier done pulse
mul_busy  in  1  multiplier busy
mul_y  in  32  multiplier result
cur_idx  out  IDX_W  index of the granted requester (debug)

Behaviour:
- Reset values: req_grant=0, resp_valid=0, resp_y=0, mul_start=0, mul_a=0, mul_b=0, cur_idx=0, state=IDLE, rr_ptr=NUM_REQ-1 (requester 0 wins first).
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
- IDLE: arbitrate only when |req_valid and mul_busy=0 and mul_ready=0. The multiplier has no reset and its ready pulse coincides with busy=1, so a stale completion after reset is never mistaken for a new one.
  - Winner: first asserted bit searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - Registered: req_grant[winner]=1 for one cycle; mul_a/mul_b latched from the winner's slices; cur_idx=winner; rr_ptr=winner; go to ISSUE.
- ISSUE: mul_start=1 for exactly one cycle; go to WAIT. mul_a and mul_b hold until the next grant.
- WAIT: mul_start=0. On mul_ready=1, capture mul_y into resp_y and go to DELIVER. mul_ready in the first WAIT cycle is ignored, because the multiplier needs at least 3 cycles.
- DELIVER: resp_valid[cur_idx]=1 for one cycle; go to IDLE. The next grant may occur in the cycle after DELIVER.
- Latency, grant to resp_valid: multiplier latency + 3 cycles.
- No result interpretation: NaN and infinity results pass through bit-exact.
- Fairness: with all requesters continuously valid, grant order is 0,1,…,NUM_REQ-1,0,…
- Requester index reads as 0 for the low slice; slices above NUM_REQ are not present.
- Boundary rules:
  - req_valid deasserting before grant: no grant, no effect.
  - A new request from the requester currently being served: waits its round-robin turn.
  - Reset in any state: returns to IDLE in the next cycle; any pending result is discarded and no resp_valid pulse is issued.

Optional Feature:
FPMUL_ARB_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT.
  - If mul_ready is absent for TIMEOUT_CYCLES cycles, go to DELIVER with resp_y=32'h7F800001 (the team's canonical NaN).
  - Add output port timeout_err (1-bit), a one-cycle pulse coincident with that resp_valid.
  - Afterwards, IDLE still waits for mul_busy=0 and mul_ready=0 before the next grant.
- Undefined: no counter, no timeout_err port; WAIT waits indefinitely.

Decomposition:
- Package fpmul_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, DELIVER);
  - FP_NAN=32'h7F800001;
  - FP_W=32.
- One sub-module, rr_pick: combinational round-robin priority selector.
  - Inputs: req vector, rr_ptr.
  - Outputs: winner index, any-valid.
- The multiplier itself is instantiated by the parent, not inside this block.

Test Plan:
1. Only req 0 valid, A=32'h40000000, B=32'h40400000, with the real multiplier -> req_grant=0001; one mul_start; resp_valid=0001 with resp_y=32'h40C00000.
2. All 4 valid continuously with distinct operands -> grants in order 0,1,2,3,0; each resp_y matches its operands; never two requests in flight.
3. Req 2 valid with A=32'h7F800000 (+inf), B=32'h3F800000 -> resp_y=32'h7F800000 to requester 2.
4. Reset asserted in WAIT, stub multiplier pulses ready 2 cycles later with busy=1 -> no resp_valid; the first post-reset grant goes to req 0 only after busy=0 and ready=0.
5. Stub holds mul_busy=1 in IDLE with req 1 valid -> no grant until busy drops; then a grant in the next cycle.
6. FPMUL_ARB_TIMEOUT_EN defined, stub never asserts ready -> after 64 WAIT cycles, resp_valid to the granted requester with resp_y=32'h7F800001 and timeout_err=1.
